// File: rtl/ivt_violation_responder.sv
// ivt_violation_responder
// Reacts to the protection monitors dropping exec: logs the violation,
// holds a PUC request for RST_CYCLES cycles, then waits for the CPU to
// re-enter the reset handler with exec restored before re-arming.
//
// state            | meaning
// -----------------+-----------------------------------------------------
// ST_IDLE          | armed, watching exec_in for a kill
// ST_RESET_HOLD    | puc_req asserted, hold counter running down
// ST_WAIT_HANDLER  | waiting for pc == RESET_HANDLER with exec_in == 1

module ivt_violation_responder #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOG_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exec_in,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic        data_en,
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic        rd_en,
  input  logic        ovf_clr,
  output logic        puc_req,
  output logic        log_valid,
  output logic [1:0]  log_src,
  output logic [15:0] log_pc,
  output logic [15:0] log_addr,
  output logic [3:0]  log_count,
  output logic        overflow,
  output logic [7:0]  viol_count,
  output logic        armed
);

  localparam int unsigned PTR_W     = $clog2(LOG_DEPTH);
  localparam logic [7:0]  HOLD_INIT = 8'(RST_CYCLES - 1);
  localparam logic [3:0]  DEPTH_C   = 4'(LOG_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_RESET_HOLD   = 2'd1,
    ST_WAIT_HANDLER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic               puc_req_q, puc_req_d;
  logic               armed_q, armed_d;

  logic [1:0]         src_mem_q  [LOG_DEPTH];
  logic [1:0]         src_mem_d  [LOG_DEPTH];
  logic [15:0]        pc_mem_q   [LOG_DEPTH];
  logic [15:0]        pc_mem_d   [LOG_DEPTH];
  logic [15:0]        addr_mem_q [LOG_DEPTH];
  logic [15:0]        addr_mem_d [LOG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]         count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         viol_q, viol_d;

  logic               capture;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;
  logic [1:0]         rec_src;
  logic [15:0]        rec_addr;

  // Violation record built from the same-cycle bus state; data bus wins over DMA.
  always_comb begin
    rec_src  = {dma_en, data_en};
    rec_addr = 16'h0000;
    if (data_en) begin
      rec_addr = data_addr;
    end else if (dma_en) begin
      rec_addr = dma_addr;
    end
  end

  // Only the first kill cycle seen while armed produces a record.
  always_comb begin
    capture = (state_q == ST_IDLE) && !exec_in;
    full    = (count_q == DEPTH_C);
    pop     = rd_en && (count_q != 4'd0);
    push_ok = capture && (!full || pop);
    drop    = capture && full && !pop;
  end

  // FSM next-state, hold counter and registered decode of puc_req/armed.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!exec_in) begin
          state_d    = ST_RESET_HOLD;
          hold_cnt_d = HOLD_INIT;
        end
      end
      ST_RESET_HOLD: begin
        if (hold_cnt_q == 8'd0) begin
          state_d = ST_WAIT_HANDLER;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      ST_WAIT_HANDLER: begin
        if ((pc == RESET_HANDLER) && exec_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_WAIT_HANDLER;
      end
    endcase
    puc_req_d = (state_d == ST_RESET_HOLD);
    armed_d   = (state_d == ST_IDLE);
  end

  // FSM state register with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT_HANDLER;
      hold_cnt_q <= 8'd0;
      puc_req_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      puc_req_q  <= puc_req_d;
      armed_q    <= armed_d;
    end
  end

  // Log FIFO next state: simultaneous push and pop is allowed even when full.
  always_comb begin
    src_mem_d  = src_mem_q;
    pc_mem_d   = pc_mem_q;
    addr_mem_d = addr_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      src_mem_d[wr_ptr_q]  = rec_src;
      pc_mem_d[wr_ptr_q]   = pc;
      addr_mem_d[wr_ptr_q] = rec_addr;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + 4'd1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 4'd1;
    end
  end

  // Log FIFO storage and pointers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(LOG_DEPTH); i++) begin
        src_mem_q[i]  <= 2'b00;
        pc_mem_q[i]   <= 16'h0000;
        addr_mem_q[i] <= 16'h0000;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      src_mem_q  <= src_mem_d;
      pc_mem_q   <= pc_mem_d;
      addr_mem_q <= addr_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Sticky overflow (a drop beats a same-cycle clear) and saturating violation count.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    viol_d = viol_q;
    if (capture && (viol_q != 8'hFF)) begin
      viol_d = viol_q + 8'd1;
    end
  end

  // Status register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      viol_q     <= 8'd0;
    end else begin
      overflow_q <= overflow_d;
      viol_q     <= viol_d;
    end
  end

  assign puc_req    = puc_req_q;
  assign armed      = armed_q;
  assign log_valid  = (count_q != 4'd0);
  assign log_count  = count_q;
  assign log_src    = src_mem_q[rd_ptr_q];
  assign log_pc     = pc_mem_q[rd_ptr_q];
  assign log_addr   = addr_mem_q[rd_ptr_q];
  assign overflow   = overflow_q;
  assign viol_count = viol_q;

endmodule

// File: tb/tb_ivt_violation_responder.sv
// Scoreboard bench for ivt_violation_responder: expected records are queued
// when a violation is issued and compared by a monitor whenever a pop occurs.

module tb_ivt_violation_responder;

  localparam int RST_CYCLES = 8;
  localparam int LOG_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        exec_in;
  logic [15:0] pc;
  logic [15:0] data_addr;
  logic        data_en;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        rd_en;
  logic        ovf_clr;
  logic        puc_req;
  logic        log_valid;
  logic [1:0]  log_src;
  logic [15:0] log_pc;
  logic [15:0] log_addr;
  logic [3:0]  log_count;
  logic        overflow;
  logic [7:0]  viol_count;
  logic        armed;

  int n_pass  = 0;
  int n_total = 0;

  logic [33:0] exp_q[$];
  int          exp_count = 0;
  logic        exp_ovf   = 1'b0;
  int          exp_viol  = 0;
  logic [33:0] mon_e;

  ivt_violation_responder #(
    .RESET_HANDLER (16'h0000),
    .RST_CYCLES    (RST_CYCLES),
    .LOG_DEPTH     (LOG_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .exec_in    (exec_in),
    .pc         (pc),
    .data_addr  (data_addr),
    .data_en    (data_en),
    .dma_addr   (dma_addr),
    .dma_en     (dma_en),
    .rd_en      (rd_en),
    .ovf_clr    (ovf_clr),
    .puc_req    (puc_req),
    .log_valid  (log_valid),
    .log_src    (log_src),
    .log_pc     (log_pc),
    .log_addr   (log_addr),
    .log_count  (log_count),
    .overflow   (overflow),
    .viol_count (viol_count),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every head the DUT hands out on a pop must match the oldest expected record.
  always @(negedge clk) begin
    if (!reset && rd_en && log_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_pop: DUT popped src=%0h pc=%0h addr=%0h but no record expected",
                 log_src, log_pc, log_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_src",  {30'd0, log_src}, {30'd0, mon_e[33:32]});
        check("sb_pc",   {16'd0, log_pc},   {16'd0, mon_e[31:16]});
        check("sb_addr", {16'd0, log_addr}, {16'd0, mon_e[15:0]});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One kill episode: detect, measure the PUC pulse, linger in WAIT, then re-arm.
  task automatic episode(input logic den, input logic dmen, input logic [15:0] da,
                         input logic [15:0] ma, input logic [15:0] p,
                         input logic pop, input logic clr);
    logic [1:0]  s;
    logic [15:0] a;
    logic        pop_eff, push_ok, was_empty;
    int          n;
    s = {dmen, den};
    a = den ? da : (dmen ? ma : 16'h0000);
    check("armed_pre", {31'd0, armed}, 32'd1);
    pop_eff   = pop && (exp_count > 0);
    push_ok   = (exp_count < LOG_DEPTH) || pop_eff;
    was_empty = (exp_count == 0);
    if (push_ok) exp_q.push_back({s, p, a});
    exp_count = exp_count + (push_ok ? 1 : 0) - (pop_eff ? 1 : 0);
    if (!push_ok) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    if (exp_viol < 255) exp_viol++;

    exec_in = 1'b0; pc = p; data_en = den; dma_en = dmen;
    data_addr = da; dma_addr = ma; rd_en = pop; ovf_clr = clr;
    tick();
    data_en = 1'b0; dma_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; pc = 16'h4000;
    data_addr = 16'h5555; dma_addr = 16'h6666;
    if (was_empty) begin
      check("head_valid", {31'd0, log_valid}, 32'd1);
      check("head_src",   {30'd0, log_src},   {30'd0, s});
      check("head_pc",    {16'd0, log_pc},    {16'd0, p});
      check("head_addr",  {16'd0, log_addr},  {16'd0, a});
    end
    check("viol_count", {24'd0, viol_count}, 32'(exp_viol));
    check("log_count",  {28'd0, log_count},  32'(exp_count));
    check("overflow",   {31'd0, overflow},   {31'd0, exp_ovf});
    n = 0;
    while (puc_req && n < 400) begin
      n++;
      tick();
    end
    check("puc_len", 32'(n), 32'(RST_CYCLES));
    tick();
    tick();
    check("wait_unarmed", {31'd0, armed}, 32'd0);
    check("no_second_rec", {24'd0, viol_count}, 32'(exp_viol));
    check("no_second_push", {28'd0, log_count}, 32'(exp_count));
    exec_in = 1'b1; pc = 16'h0000;
    tick();
    check("rearm", {31'd0, armed}, 32'd1);
  endtask

  task automatic pop_one;
    if (exp_count > 0) exp_count--;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_count", {28'd0, log_count}, 32'(exp_count));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; exec_in = 1'b1; pc = 16'h0000; data_addr = 16'h0000; data_en = 1'b0;
    dma_addr = 16'h0000; dma_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    tick(); tick(); tick();
    check("rst_armed",   {31'd0, armed},      32'd0);
    check("rst_puc",     {31'd0, puc_req},    32'd0);
    check("rst_valid",   {31'd0, log_valid},  32'd0);
    check("rst_count",   {28'd0, log_count},  32'd0);
    check("rst_ovf",     {31'd0, overflow},   32'd0);
    check("rst_viol",    {24'd0, viol_count}, 32'd0);
    check("rst_head",    {log_src, log_pc, log_addr[13:0]}, 32'd0);
    reset = 1'b0;
    tick();
    check("arm_after_rst", {31'd0, armed}, 32'd1);
    check("arm_puc",       {31'd0, puc_req}, 32'd0);

    // Source decode: data, DMA, both, none.
    episode(1'b1, 1'b0, 16'hFFE4, 16'h1111, 16'hE123, 1'b0, 1'b0);
    check("first_viol", {24'd0, viol_count}, 32'd1);
    episode(1'b0, 1'b1, 16'h2222, 16'hFFF0, 16'hE200, 1'b0, 1'b0);
    episode(1'b1, 1'b1, 16'hFFA0, 16'hFFB0, 16'hE300, 1'b0, 1'b0);
    episode(1'b0, 1'b0, 16'h3333, 16'h4444, 16'hE400, 1'b0, 1'b0);
    // Fifth episode overflows the 4-entry log.
    episode(1'b1, 1'b0, 16'h0500, 16'h0000, 16'hE500, 1'b0, 1'b0);
    check("full_count", {28'd0, log_count},  32'd4);
    check("full_ovf",   {31'd0, overflow},   32'd1);
    check("full_viol",  {24'd0, viol_count}, 32'd5);
    check("full_head",  {16'd0, log_pc},     32'h0000E123);

    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);
    exp_ovf = 1'b0;
    // Push with a pop while full: no drop.
    episode(1'b1, 1'b0, 16'h0600, 16'h0000, 16'hE600, 1'b1, 1'b0);
    check("pp_full_ovf",   {31'd0, overflow},  32'd0);
    check("pp_full_count", {28'd0, log_count}, 32'd4);
    // Drop with a same-cycle clear: set wins.
    episode(1'b0, 1'b1, 16'h0000, 16'h0700, 16'hE700, 1'b0, 1'b1);
    check("set_wins", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr2", {31'd0, overflow}, 32'd0);
    exp_ovf = 1'b0;

    for (int i = 0; i < 4; i++) pop_one();
    check("drained", {31'd0, log_valid}, 32'd0);
    pop_one();
    check("pop_empty", {28'd0, log_count}, 32'd0);

    // Reset in the middle of a PUC hold.
    episode(1'b1, 1'b0, 16'h0800, 16'h0000, 16'hE800, 1'b0, 1'b0);
    exec_in = 1'b0; data_en = 1'b1; data_addr = 16'h0900; pc = 16'hE900;
    tick();
    data_en = 1'b0;
    check("hold_puc", {31'd0, puc_req}, 32'd1);
    reset = 1'b1;
    tick();
    exp_q.delete(); exp_count = 0; exp_ovf = 1'b0; exp_viol = 0;
    check("mid_rst_puc",   {31'd0, puc_req},   32'd0);
    check("mid_rst_count", {28'd0, log_count}, 32'd0);
    check("mid_rst_valid", {31'd0, log_valid}, 32'd0);
    check("mid_rst_armed", {31'd0, armed},     32'd0);
    reset = 1'b0; exec_in = 1'b1; pc = 16'h1234;
    tick(); tick(); tick();
    check("wrong_pc_unarmed", {31'd0, armed}, 32'd0);
    pc = 16'h0000;
    tick();
    check("handler_armed", {31'd0, armed}, 32'd1);

    // Saturation of the violation counter.
    for (int i = 0; i < 260; i++) begin
      episode(i[0], i[1], 16'(i), 16'(i + 1000), 16'(i + 16'h8000), 1'b0, 1'b0);
    end
    check("viol_sat",  {24'd0, viol_count}, 32'd255);
    check("sat_ovf",   {31'd0, overflow},   32'd1);
    check("sat_count", {28'd0, log_count},  32'd4);
    for (int i = 0; i < 4; i++) pop_one();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
